// File: rtl/controladora.sv
// Lighting/load controller: debounced push button (short/long press) plus
// IR presence sensor driving a load enable, with an absence shutdown timer.
module controladora #(
  parameter int unsigned DEBOUNCE_P        = 300,
  parameter int unsigned SWITCH_MODE_MIN_T = 5000,
  parameter int unsigned AUTO_SHUTDOWN_T   = 30000
) (
  input  logic clk,
  input  logic rst,
  input  logic infravermelho,
  input  logic push_button,
  output logic led,
  output logic saida
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_P + 1);
  localparam int unsigned HOLD_W = $clog2(SWITCH_MODE_MIN_T + 1);

  typedef enum logic [1:0] {
    INICIAL  = 2'd0,
    CONTANDO = 2'd1,
    TEMP     = 2'd2
  } estado_t;

  estado_t     estado, estado_nx;
  logic [31:0] Tc, tc_nx;

  logic [1:0]        btn_sync;
  logic              btn;
  logic              btn_db;
  logic              btn_db_q;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold;
  logic              fall_c;
  logic              long_p;
  logic              short_p;
  logic              c;
  logic              enable;

  assign btn    = btn_sync[1];
  assign fall_c = btn_db_q & ~btn_db;
  // Shutdown pulse: high for the single cycle spent in TEMP.
  assign c      = (estado == TEMP);
  // led doubles as the mode register: 1 = MANUAL, 0 = AUTO.
  assign enable = saida & ~led;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_sync <= '0;
    else     btn_sync <= {btn_sync[0], push_button};
  end

  // Debounce: adopt a new level after DEBOUNCE_P consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn != btn_db) begin
      if (db_cnt == DB_W'(DEBOUNCE_P - 1)) begin
        btn_db <= btn;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Hold-time measurement and press classification on the debounced falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db_q <= 1'b0;
      hold     <= '0;
      long_p   <= 1'b0;
      short_p  <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      long_p   <= fall_c && (hold >= HOLD_W'(SWITCH_MODE_MIN_T));
      short_p  <= fall_c && (hold <  HOLD_W'(SWITCH_MODE_MIN_T));
      if (fall_c) begin
        hold <= '0;
      end else if (btn_db && (hold != HOLD_W'(SWITCH_MODE_MIN_T))) begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end

  // Mode and load enable; a long press takes priority over every other source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led   <= 1'b0;
      saida <= 1'b0;
    end else if (long_p) begin
      led <= ~led;
      if (led) saida <= infravermelho;
    end else if (led) begin
      if (short_p) saida <= ~saida;
    end else if (infravermelho) begin
      saida <= 1'b1;
    end else if (c) begin
      saida <= 1'b0;
    end
  end

  // Absence timer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= INICIAL;
      Tc     <= '0;
    end else begin
      estado <= estado_nx;
      Tc     <= tc_nx;
    end
  end

  // Absence timer next state; leaving CONTANDO outranks the timeout.
  always_comb begin
    estado_nx = estado;
    tc_nx     = Tc;
    case (estado)
      INICIAL: begin
        tc_nx = '0;
        if (enable && !infravermelho) estado_nx = CONTANDO;
      end
      CONTANDO: begin
        if (infravermelho || !enable) begin
          estado_nx = INICIAL;
          tc_nx     = '0;
        end else if (Tc == 32'(AUTO_SHUTDOWN_T)) begin
          estado_nx = TEMP;
          tc_nx     = '0;
        end else begin
          tc_nx = Tc + 32'd1;
        end
      end
      TEMP: begin
        estado_nx = INICIAL;
        tc_nx     = '0;
      end
      default: begin
        estado_nx = INICIAL;
        tc_nx     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_controladora.sv
// Bench for controladora: directed scenarios plus random button/IR segments,
// checked every cycle against a timestamp-based reference model.
module tb_controladora;

  localparam int DEB  = 300;
  localparam int MINT = 5000;
  localparam int TOUT = 30000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic infravermelho = 1'b0;
  logic push_button = 1'b0;
  logic led;
  logic saida;

  controladora dut (
    .clk           (clk),
    .rst           (rst),
    .infravermelho (infravermelho),
    .push_button   (push_button),
    .led           (led),
    .saida         (saida)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model state.
  int   m_cyc;
  logic m_b1, m_b2, m_db;
  int   m_run;
  int   m_rise;
  int   m_pend_at;
  bit   m_pend_long;
  logic m_manual, m_saida;
  int   m_phase;   // 0 idle, 1 counting absence, 2 shutdown pulse
  int   m_tc;

  // Model: debounce by run length, press length from rise/fall timestamps,
  // press effect lands two edges after the debounced release.
  always @(posedge clk or posedge rst) begin : model
    logic ev_long, ev_short, pulse, en, ns;
    if (rst) begin
      m_cyc = 0; m_b1 = 0; m_b2 = 0; m_db = 0; m_run = 0; m_rise = 0;
      m_pend_at = -1; m_pend_long = 0; m_manual = 0; m_saida = 0;
      m_phase = 0; m_tc = 0;
    end else begin
      ev_long  = (m_pend_at == m_cyc) && m_pend_long;
      ev_short = (m_pend_at == m_cyc) && !m_pend_long;
      pulse    = (m_phase == 2);
      en       = m_saida && !m_manual;
      if (ev_long)       ns = m_manual ? infravermelho : m_saida;
      else if (m_manual) ns = ev_short ? !m_saida : m_saida;
      else if (infravermelho) ns = 1'b1;
      else if (pulse)    ns = 1'b0;
      else               ns = m_saida;
      case (m_phase)
        0: begin
          m_tc = 0;
          if (en && !infravermelho) m_phase = 1;
        end
        1: begin
          if (infravermelho || !en) begin m_phase = 0; m_tc = 0; end
          else if (m_tc == TOUT)    begin m_phase = 2; m_tc = 0; end
          else m_tc++;
        end
        default: begin m_phase = 0; m_tc = 0; end
      endcase
      if (ev_long) m_manual = !m_manual;
      m_saida = ns;
      if (m_b2 != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db  = m_b2;
          m_run = 0;
          if (m_db) m_rise = m_cyc;
          else begin
            m_pend_at   = m_cyc + 2;
            m_pend_long = (m_cyc - m_rise) >= MINT;
          end
        end
      end else begin
        m_run = 0;
      end
      m_b2 = m_b1;
      m_b1 = push_button;
      m_cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("model_led",    32'(led),        32'(m_manual));
      check("model_saida",  32'(saida),      32'(m_saida));
      check("model_estado", 32'(dut.estado), m_phase);
      check("model_Tc",     dut.Tc,          m_tc);
    end
  end

  task automatic run(input logic b, input logic ir, input int n);
    push_button   = b;
    infravermelho = ir;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push_button = 1'b0;
    infravermelho = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic b;
    int   r, len;

    // Reset state
    do_reset();
    chk_on = 1'b1;
    check("rst_estado", 32'(dut.estado), 0);
    check("rst_Tc",     dut.Tc,          0);
    check("rst_led",    32'(led),        0);
    check("rst_saida",  32'(saida),      0);

    // Interrupted count
    run(0, 1, 1);
    check("int_saida_on", 32'(saida), 1);
    run(0, 0, 1);
    check("int_contando", 32'(dut.estado), 1);
    check("int_tc0",      dut.Tc,          0);
    run(0, 0, 100);
    check("int_tc100",    dut.Tc,          100);
    run(0, 1, 1);
    check("int_back_estado", 32'(dut.estado), 0);
    check("int_back_tc",     dut.Tc,          0);
    check("int_back_saida",  32'(saida),      1);

    // Timeout
    do_reset();
    run(0, 1, 1);
    check("to_saida_on", 32'(saida), 1);
    run(0, 0, 1);
    check("to_contando", 32'(dut.estado), 1);
    run(0, 0, TOUT);
    check("to_tc_max",   dut.Tc, TOUT);
    run(0, 0, 1);
    check("to_temp",       32'(dut.estado), 2);
    check("to_c_pulse",    32'(dut.c),      1);
    check("to_saida_held", 32'(saida),      1);
    run(0, 0, 1);
    check("to_inicial",  32'(dut.estado), 0);
    check("to_saida_off", 32'(saida),     0);
    check("to_c_low",    32'(dut.c),      0);

    // Debounce: glitches and a 299-cycle press are ignored
    for (int i = 0; i < 8; i++) begin
      run(1, 0, 10);
      run(0, 0, $urandom_range(1, 20));
    end
    run(0, 0, 20);
    check("glitch_led",   32'(led),   0);
    check("glitch_saida", 32'(saida), 0);
    run(1, 0, 299);
    run(0, 0, 400);
    check("p299_led",   32'(led),   0);
    check("p299_saida", 32'(saida), 0);
    check("p299_db",    32'(dut.btn_db), 0);

    // Long press to MANUAL, then two short presses toggle the load
    run(1, 0, 6000);
    run(0, 0, 400);
    check("long_led",   32'(led),   1);
    check("long_saida", 32'(saida), 0);
    run(1, 0, 1000);
    run(0, 0, 400);
    check("short1_saida", 32'(saida), 1);
    run(1, 0, 1000);
    run(0, 0, 400);
    check("short2_saida", 32'(saida), 0);

    // MANUAL ignores IR; long press back to AUTO samples IR
    run(0, 1, 50);
    check("man_ir_saida",  32'(saida),      0);
    check("man_ir_estado", 32'(dut.estado), 0);
    run(1, 1, 6000);
    run(0, 1, 400);
    check("auto_led",   32'(led),   0);
    check("auto_saida", 32'(saida), 1);

    // Random button/IR segments, including presses near the long threshold
    b = 1'b0;
    for (int s = 0; s < 16; s++) begin
      b = ~b;
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2: len = $urandom_range(1, 60);
        3:       len = $urandom_range(200, 400);
        4, 5:    len = $urandom_range(700, 1500);
        6:       len = $urandom_range(5000, 5600);
        default: len = $urandom_range(4995, 5005);
      endcase
      run(b, 1'($urandom_range(0, 1)), len);
    end
    run(0, 0, 500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
